// File: rtl/hazard_stall_unit.sv
// ID-stage hazard controller: load-use stall, redirect flush and data-memory freeze.
// Optional statistics counters are enabled by defining HAZARD_STATS_EN.
module hazard_stall_unit #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_useRs,
  input  logic             id_useRt,
  input  logic [4:0]       ex_regAw,
  input  logic             ex_memRead,
  input  logic             ex_branchTaken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] freeze_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } state_e;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       lu;

  // Load-use hazard detection; r0 is hardwired and never creates a dependency
  always_comb begin
    lu = ex_memRead && (ex_regAw != 5'd0) &&
         ((id_useRs && (id_rs == ex_regAw)) || (id_useRt && (id_rt == ex_regAw)));
  end

  // Output decode and next-state selection in priority order
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = RUN;
      fcnt_d      = 3'd0;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
    end else if (ex_branchTaken) begin
      // ID holds a wrong-path instruction, so the redirect beats any load-use stall
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        fcnt_d  = FLUSH_RELOAD;
      end else begin
        state_d = RUN;
        fcnt_d  = 3'd0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_d     = LOAD_STALL;
          end else begin
            state_d = RUN;
          end
        end
        LOAD_STALL: begin
          state_d = RUN;
        end
        FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (fcnt_q <= 3'd1) begin
            state_d = RUN;
            fcnt_d  = 3'd0;
          end else begin
            fcnt_d = fcnt_q - 3'd1;
          end
        end
        default: begin
          state_d = RUN;
          fcnt_d  = 3'd0;
        end
      endcase
    end
  end

  // State and flush counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      fcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic             stall_acc, redirect_acc, freeze_acc;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

  // Qualifying events and saturating increments
  always_comb begin
    stall_acc    = !reset && !mem_busy && !ex_branchTaken && (state_q == RUN) && lu;
    redirect_acc = !reset && !mem_busy && ex_branchTaken;
    freeze_acc   = !reset && mem_busy;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    if (stall_acc && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (redirect_acc && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
    if (freeze_acc && (freeze_cnt_q != {CNT_W{1'b1}})) begin
      freeze_cnt_d = freeze_cnt_q + CNT_W'(1);
    end else begin
      freeze_cnt_d = freeze_cnt_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= {CNT_W{1'b0}};
      flush_cnt_q  <= {CNT_W{1'b0}};
      freeze_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign stall_count  = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
  assign freeze_count = freeze_cnt_q;
`else
  assign stall_count  = {CNT_W{1'b0}};
  assign flush_count  = {CNT_W{1'b0}};
  assign freeze_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed cycle table, counter saturation sequence,
// and randomized traffic against a behavioural model.
module tb_hazard_stall_unit;
  localparam int FC = 2;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [6:0] O_DEF = 7'b11111_00;
  localparam logic [6:0] O_RST = 7'b00000_11;
  localparam logic [6:0] O_FRZ = 7'b00000_00;
  localparam logic [6:0] O_FL  = 7'b11111_11;
  localparam logic [6:0] O_ST  = 7'b00111_01;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [4:0]    id_rs, id_rt, ex_regAw;
  logic          id_useRs, id_useRt, ex_memRead, ex_branchTaken, mem_busy;
  logic          pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic          ifid_flush, idex_bubble;
  logic [CW-1:0] stall_count, flush_count, freeze_count;

  hazard_stall_unit #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_useRs(id_useRs), .id_useRt(id_useRt),
    .ex_regAw(ex_regAw), .ex_memRead(ex_memRead),
    .ex_branchTaken(ex_branchTaken), .mem_busy(mem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .memwb_write(memwb_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .stall_count(stall_count), .flush_count(flush_count), .freeze_count(freeze_count)
  );

  int checks = 0;
  int errors = 0;

  // Model: flush cycles still owed, whether last accepted cycle was a stall, counters
  int m_flush_left = 0;
  bit m_stalled    = 1'b0;
  int m_stall_c = 0, m_flush_c = 0, m_freeze_c = 0;

  typedef struct {
    bit         rst, br, busy, mr, urs, urt;
    logic [4:0] aw, rs, rt;
    logic [6:0] exp;
  } vec_t;

  vec_t tab[27];

  function automatic vec_t mk(bit rst, bit br, bit busy, bit mr, logic [4:0] aw,
                              logic [4:0] rs, bit urs, logic [4:0] rt, bit urt,
                              logic [6:0] exp);
    vec_t v;
    v.rst = rst; v.br = br; v.busy = busy; v.mr = mr; v.aw = aw;
    v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt; v.exp = exp;
    return v;
  endfunction

  function automatic bit hazard();
    if (!ex_memRead || ex_regAw == 5'd0) return 1'b0;
    return (id_useRs && id_rs == ex_regAw) || (id_useRt && id_rt == ex_regAw);
  endfunction

  function automatic logic [6:0] model_out();
    if (reset)                                   return O_RST;
    if (mem_busy)                                return O_FRZ;
    if (ex_branchTaken || m_flush_left > 0)      return O_FL;
    if (hazard() && !m_stalled)                  return O_ST;
    return O_DEF;
  endfunction

  function automatic int sat_inc(int v);
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  task automatic model_update();
    if (reset) begin
      m_flush_left = 0; m_stalled = 1'b0;
      m_stall_c = 0; m_flush_c = 0; m_freeze_c = 0;
    end else if (mem_busy) begin
      m_freeze_c = sat_inc(m_freeze_c);
    end else if (ex_branchTaken) begin
      m_flush_c = sat_inc(m_flush_c);
      m_flush_left = FC - 1;
      m_stalled = 1'b0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
      m_stalled = 1'b0;
    end else if (hazard() && !m_stalled) begin
      m_stall_c = sat_inc(m_stall_c);
      m_stalled = 1'b1;
    end else begin
      m_stalled = 1'b0;
    end
  endtask

  task automatic drive(bit rst, bit br, bit busy, bit mr, logic [4:0] aw,
                       logic [4:0] rs, bit urs, logic [4:0] rt, bit urt);
    reset = rst; ex_branchTaken = br; mem_busy = busy; ex_memRead = mr;
    ex_regAw = aw; id_rs = rs; id_useRs = urs; id_rt = rt; id_useRt = urt;
  endtask

  // Called just after a falling edge with inputs already applied
  task automatic step(input logic [6:0] exp_tab, input bit use_tab, input string name);
    logic [6:0]      got, exp;
    logic [3*CW-1:0] got_c, exp_c;
    #1;
    got = {pc_write, ifid_write, idex_write, exmem_write, memwb_write, ifid_flush, idex_bubble};
    exp = use_tab ? exp_tab : model_out();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s ctrl @%0t: got %b expected %b", name, $time, got, exp);
    end
    got_c = {stall_count, flush_count, freeze_count};
`ifdef HAZARD_STATS_EN
    exp_c = {CW'(m_stall_c), CW'(m_flush_c), CW'(m_freeze_c)};
`else
    exp_c = '0;
`endif
    checks++;
    if (got_c !== exp_c) begin
      errors++;
      $display("FAIL %s counters @%0t: got %h expected %h", name, $time, got_c, exp_c);
    end
    model_update();
    @(negedge clk);
  endtask

  initial begin
    tab[0]  = mk(1,0,0,0,0,0,0,0,0, O_RST);
    tab[1]  = mk(1,0,0,0,0,0,0,0,0, O_RST);
    tab[2]  = mk(0,0,0,0,0,0,0,0,0, O_DEF);
    tab[3]  = mk(0,0,0,1,5,5,1,0,0, O_ST);
    tab[4]  = mk(0,0,0,1,5,5,1,0,0, O_DEF);
    tab[5]  = mk(0,0,0,1,5,5,1,0,0, O_ST);
    tab[6]  = mk(0,0,0,0,0,0,0,0,0, O_DEF);
    tab[7]  = mk(0,0,0,1,0,0,1,0,1, O_DEF);
    tab[8]  = mk(0,0,0,1,5,5,0,3,1, O_DEF);
    tab[9]  = mk(0,0,0,1,5,0,0,5,1, O_ST);
    tab[10] = mk(0,0,0,0,0,0,0,0,0, O_DEF);
    tab[11] = mk(0,1,0,1,5,5,1,0,0, O_FL);
    tab[12] = mk(0,0,0,1,5,5,1,0,0, O_FL);
    tab[13] = mk(0,0,0,1,5,5,1,0,0, O_ST);
    tab[14] = mk(0,1,0,0,0,0,0,0,0, O_FL);
    tab[15] = mk(0,0,1,0,0,0,0,0,0, O_FRZ);
    tab[16] = mk(0,0,1,0,0,0,0,0,0, O_FRZ);
    tab[17] = mk(0,0,1,0,0,0,0,0,0, O_FRZ);
    tab[18] = mk(0,0,0,0,0,0,0,0,0, O_FL);
    tab[19] = mk(0,0,0,0,0,0,0,0,0, O_DEF);
    tab[20] = mk(0,0,0,1,7,7,1,0,0, O_ST);
    tab[21] = mk(1,0,0,1,7,7,1,0,0, O_RST);
    tab[22] = mk(0,0,0,1,7,7,1,0,0, O_ST);
    tab[23] = mk(0,1,1,0,0,0,0,0,0, O_FRZ);
    tab[24] = mk(0,1,0,0,0,0,0,0,0, O_FL);
    tab[25] = mk(1,0,0,0,0,0,0,0,0, O_RST);
    tab[26] = mk(0,0,0,0,0,0,0,0,0, O_DEF);

    drive(1,0,0,0,0,0,0,0,0);
    @(negedge clk);

    for (int i = 0; i < 27; i++) begin
      drive(tab[i].rst, tab[i].br, tab[i].busy, tab[i].mr, tab[i].aw,
            tab[i].rs, tab[i].urs, tab[i].rt, tab[i].urt);
      step(tab[i].exp, 1'b1, $sformatf("tab%0d", i));
    end

    // Five separate load-use stalls saturate a 2-bit stall counter
    for (int i = 0; i < 5; i++) begin
      drive(0,0,0,1,9,9,1,0,0);
      step(O_ST, 1'b1, "sat_stall");
      drive(0,0,0,0,0,0,0,0,0);
      step(O_DEF, 1'b1, "sat_idle");
    end
    #1;
    checks++;
`ifdef HAZARD_STATS_EN
    if (stall_count !== 2'd3) begin
`else
    if (stall_count !== 2'd0) begin
`endif
      errors++;
      $display("FAIL stall_sat: got %0d", stall_count);
    end
    @(negedge clk);

    // Randomized traffic over a small register set to provoke frequent hazards
    drive(1,0,0,0,0,0,0,0,0);
    step(O_RST, 1'b1, "rnd_reset");
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 12),
            ($urandom_range(0, 99) < 15), ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1));
      step(7'd0, 1'b0, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline hazard controller that sits in the ID stage and complements the EX-stage forwarding unit.
- The forwarding unit steers results *to* consumers. This block handles the cases forwarding cannot cover: it holds back producers' consumers (load-use), flushes wrong-path instructions (taken branch/jump resolved in EX) and freezes the whole pipe on data-memory wait.
- Drives write-enables and flush/bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- FLUSH_CYCLES, 1: cycles ifid_flush/idex_bubble stay asserted after a taken redirect; legal 1..7.
- CNT_W, 32: width of statistics counters (optional feature only).

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- id_rs  input  5  rs field of instruction in ID.
- id_rt  input  5  rt field of instruction in ID.
- id_useRs  input  1  ID instruction reads rs.
- id_useRt  input  1  ID instruction reads rt.
- ex_regAw  input  5  destination register of instruction in EX.
- ex_memRead  input  1  EX instruction is a load.
- ex_branchTaken  input  1  branch/jump in EX resolved taken (redirect).
- mem_busy  input  1  data memory not ready; pipeline must freeze.
- pc_write  output  1  PC update enable.
- ifid_write  output  1  IF/ID register enable.
- idex_write  output  1  ID/EX register enable.
- exmem_write  output  1  EX/MEM register enable.
- memwb_write  output  1  MEM/WB register enable.
- ifid_flush  output  1  load NOP into IF/ID.
- idex_bubble  output  1  load NOP (all control zero) into ID/EX.
- stall_count  output  CNT_W  load-use stall cycles (optional feature).
- flush_count  output  CNT_W  redirect events (optional feature).
- freeze_count  output  CNT_W  mem_busy cycles (optional feature).

Behaviour:
- Outputs are combinational from the registered state plus current inputs (Mealy); the state register and flush counter update on posedge clk.
- States: RUN, LOAD_STALL, FLUSH.
- Reset:
  - While reset=1: all *_write=0, ifid_flush=1, idex_bubble=1.
  - Next state RUN, flush counter 0, stats counters 0.
- Default in RUN with no event: all *_write=1, ifid_flush=0, idex_bubble=0.
- Load-use hazard: lu = ex_memRead && ex_regAw!=0 && ((id_useRs && id_rs==ex_regAw) || (id_useRt && id_rt==ex_regAw)). Register 0 never triggers.
- Priority, highest first:
  1. mem_busy: all *_write=0 and flush/bubble=0. State and flush counter hold. No other event is taken this cycle; it is re-evaluated when mem_busy drops.
  2. ex_branchTaken: ifid_flush=1, idex_bubble=1, all writes=1. This overrides lu because the ID instruction is wrong-path.
     - If FLUSH_CYCLES>1: next state FLUSH with counter=FLUSH_CYCLES-1.
     - Otherwise: next state RUN.
  3. lu (only in RUN): pc_write=0, ifid_write=0, idex_bubble=1, other writes=1. Next state LOAD_STALL.
- LOAD_STALL:
  - Lasts exactly one non-frozen cycle, outputs at default. The load is now in MEM and the forwarding unit covers it.
  - lu is ignored in this state, which guarantees exactly one bubble per load.
  - ex_branchTaken is still honoured (priority 2).
  - Next state RUN.
- FLUSH:
  - ifid_flush=1, idex_bubble=1, writes=1; counter decrements each non-frozen cycle. Return to RUN when counter reaches 1→0.
  - A new ex_branchTaken in FLUSH reloads the counter to FLUSH_CYCLES-1.
  - lu is ignored in FLUSH.
- Reset mid-stall or mid-flush: the next cycle is RUN with counter 0. No residual bubble.
- Simultaneous mem_busy and ex_branchTaken: the freeze wins. The redirect is serviced on the first cycle mem_busy=0, provided ex_branchTaken is still held; it is held because EX is frozen.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined: three CNT_W-bit saturating counters, cleared by reset, each incrementing by 1 per qualifying cycle:
  - stall_count: cycles where lu causes a bubble.
  - flush_count: cycles where ex_branchTaken is accepted.
  - freeze_count: cycles with mem_busy=1 and reset=0.
  - Saturated counters hold at all-ones.
- Undefined: the ports still exist and are driven constant 0; no counter flops are synthesized.

Test Plan:
- Reset for 2 cycles, then release, no events → during reset writes=0 and flush/bubble=1; afterwards all writes=1 and flush/bubble=0.
- ex_memRead=1, ex_regAw=5, id_rs=5, id_useRs=1 → cycle N: pc_write=0, ifid_write=0, idex_bubble=1. Cycle N+1 with the same inputs held: defaults (no second bubble).
- Same as the previous case but ex_regAw=0, or id_useRs=0 with id_rt≠5 → no stall.
- Load-use and ex_branchTaken in the same cycle, FLUSH_CYCLES=2 → ifid_flush=1 and idex_bubble=1 for 2 cycles, pc_write=1 throughout, no LOAD_STALL entered.
- mem_busy=1 for 3 cycles during FLUSH (counter=1), then 0 → all writes=0 for 3 cycles, flush resumes for 1 cycle, then RUN.
- With HAZARD_STATS_EN and CNT_W=2: 5 load-use stalls → stall_count=3 (saturated). Without the macro → stall_count=0.
